// File: rtl/mc_switch_arbiter_pkg.sv
// Shared defaults, types and helpers for the multicast switch arbiter.
package mc_switch_arbiter_pkg;

    localparam int unsigned NUM_PORTS_DEF = 4;
    localparam int unsigned AGE_W_DEF     = 4;
    localparam int unsigned AGE_MAX_DEF   = 12;

    typedef logic [NUM_PORTS_DEF-1:0] port_mask_t;
    typedef logic [AGE_W_DEF-1:0]     age_t;

    // Round-robin successor of a port index.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/mc_switch_arbiter_rr_pick_onehot.sv
// Round-robin picker: first set request at or after ptr, returned one-hot.
module rr_pick_onehot #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         pick_c_o
);

    localparam int unsigned SEL_W = $clog2(N);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        pick_c_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = SEL_W'((32'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                pick_c_o[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_switch_arbiter.sv
// N-port multicast switch arbiter: all-or-nothing grants, per-output round-robin,
// packet-long connections and an age-based reservation for starving ports.
module mc_switch_arbiter
    import mc_switch_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned AGE_W     = AGE_W_DEF,
    parameter int unsigned AGE_MAX   = AGE_MAX_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_i,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]   dst_mask_i,
    input  logic [NUM_PORTS-1:0]             done_i,
    output logic [NUM_PORTS-1:0]             grant_o,
    output logic [NUM_PORTS-1:0]             holding_o,
    output logic [NUM_PORTS*$clog2(NUM_PORTS)-1:0] out_sel_o,
    output logic [NUM_PORTS-1:0]             out_active_o,
    output logic [NUM_PORTS-1:0]             urgent_o,
    output logic                             err_empty_dst_o
);

    localparam int unsigned N     = NUM_PORTS;
    localparam int unsigned SEL_W = $clog2(NUM_PORTS);

    typedef logic [N-1:0] vec_t;

    vec_t             mask_c [N];
    vec_t             reqv_c [N];
    vec_t             rr_c   [N];
    vec_t             pick_c [N];
    vec_t             elig_c, win_c, rel_c, reserved_c, urg_oh_c;
    logic             any_urg_c;
    logic [SEL_W-1:0] urg_idx_c;

    vec_t             holding_q, holding_d, active_q, active_d;
    vec_t             grant_q, grant_d, urgent_q, urgent_d;
    logic [SEL_W-1:0] owner_q [N], owner_d [N];
    logic [SEL_W-1:0] ptr_q   [N], ptr_d   [N];
    logic [AGE_W-1:0] age_q   [N], age_d   [N];
    logic             err_q, err_d;

    // Unpack masks, find eligible ports and the lowest-index urgent port.
    always_comb begin
        any_urg_c = 1'b0;
        urg_idx_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask_c[i] = dst_mask_i[i*N +: N];
            elig_c[i] = req_i[i] & ~holding_q[i] & (|mask_c[i]);
            if (urgent_q[i] && !any_urg_c) begin
                any_urg_c = 1'b1;
                urg_idx_c = SEL_W'(i);
            end
        end
        reserved_c = any_urg_c ? mask_c[urg_idx_c] : '0;
    end

    always_comb begin
        for (int unsigned o = 0; o < N; o++) begin
            reqv_c[o] = '0;
            for (int unsigned i = 0; i < N; i++) begin
                reqv_c[o][i] = elig_c[i] & mask_c[i][o];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        rr_pick_onehot #(.N(N)) u_rr (
            .req_i    (reqv_c[o]),
            .ptr_i    (ptr_q[o]),
            .pick_c_o (rr_c[o])
        );
        assign out_sel_o[o*SEL_W +: SEL_W] = owner_q[o];
    end

    // Reserved outputs may only go to the urgent port; the rest follow round-robin.
    always_comb begin
        urg_oh_c = N'(1) << urg_idx_c;
        for (int unsigned o = 0; o < N; o++) begin
            pick_c[o] = reserved_c[o] ? (urg_oh_c & reqv_c[o]) : rr_c[o];
        end
    end

    // A port wins only if it is picked on, and finds unlocked, every output it wants.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            win_c[i] = elig_c[i];
            for (int unsigned o = 0; o < N; o++) begin
                if (mask_c[i][o] && !(pick_c[o][i] && !active_q[o])) begin
                    win_c[i] = 1'b0;
                end
            end
        end
        rel_c = done_i & holding_q;
    end

    always_comb begin
        holding_d = (holding_q & ~rel_c) | win_c;
        grant_d   = win_c;
        err_d     = 1'b0;
        for (int unsigned o = 0; o < N; o++) begin
            active_d[o] = active_q[o];
            owner_d[o]  = owner_q[o];
            ptr_d[o]    = ptr_q[o];
            if (active_q[o] && rel_c[owner_q[o]]) begin
                active_d[o] = 1'b0;
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (win_c[i] && mask_c[i][o]) begin
                    active_d[o] = 1'b1;
                    owner_d[o]  = SEL_W'(i);
                    ptr_d[o]    = SEL_W'(rr_next(i, N));
                end
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i] && mask_c[i] == '0) begin
                err_d = 1'b1;
            end
            if (!req_i[i] || win_c[i]) begin
                age_d[i] = '0;
            end else if (elig_c[i] && age_q[i] != AGE_W'(AGE_MAX)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end else begin
                age_d[i] = age_q[i];
            end
            urgent_d[i] = (age_d[i] == AGE_W'(AGE_MAX));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holding_q <= '0;
            active_q  <= '0;
            grant_q   <= '0;
            urgent_q  <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                owner_q[i] <= '0;
                ptr_q[i]   <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            holding_q <= holding_d;
            active_q  <= active_d;
            grant_q   <= grant_d;
            urgent_q  <= urgent_d;
            err_q     <= err_d;
            for (int unsigned i = 0; i < N; i++) begin
                owner_q[i] <= owner_d[i];
                ptr_q[i]   <= ptr_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

    assign grant_o         = grant_q;
    assign holding_o       = holding_q;
    assign out_active_o    = active_q;
    assign urgent_o        = urgent_q;
    assign err_empty_dst_o = err_q;

endmodule

// File: tb/tb_mc_switch_arbiter.sv
// Directed bench for mc_switch_arbiter (4 ports, AGE_MAX 12): vector table plus
// hand sequences for starvation and mid-packet reset.
module tb_mc_switch_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req, done;
    logic [15:0] dst;
    logic [3:0]  grant, holding, out_active, urgent;
    logic [7:0]  out_sel;
    logic        err_empty_dst;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] dst;
        logic [3:0]  done;
        logic [3:0]  grant;
        logic [3:0]  hold;
        logic [3:0]  act;
        logic [7:0]  sel;
        logic [3:0]  urg;
        logic        err;
    } row_t;

    row_t tbl[$];

    mc_switch_arbiter #(.NUM_PORTS(4), .AGE_W(4), .AGE_MAX(12)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_i           (req),
        .dst_mask_i      (dst),
        .done_i          (done),
        .grant_o         (grant),
        .holding_o       (holding),
        .out_sel_o       (out_sel),
        .out_active_o    (out_active),
        .urgent_o        (urgent),
        .err_empty_dst_o (err_empty_dst)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic [3:0] r, input logic [15:0] d, input logic [3:0] dn,
                                input logic [3:0] g, input logic [3:0] h, input logic [3:0] a,
                                input logic [7:0] s, input logic [3:0] u, input logic e);
        row_t v;
        v.req = r; v.dst = d; v.done = dn; v.grant = g; v.hold = h;
        v.act = a; v.sel = s; v.urg = u; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx, input row_t v);
        chk({tag, ".grant"},   idx, 32'(grant),         32'(v.grant));
        chk({tag, ".holding"}, idx, 32'(holding),       32'(v.hold));
        chk({tag, ".active"},  idx, 32'(out_active),    32'(v.act));
        chk({tag, ".out_sel"}, idx, 32'(out_sel),       32'(v.sel));
        chk({tag, ".urgent"},  idx, 32'(urgent),        32'(v.urg));
        chk({tag, ".err"},     idx, 32'(err_empty_dst), 32'(v.err));
    endtask

    // Drive one cycle of inputs, then check the registered results after the edge.
    task automatic apply(input string tag, input int idx, input row_t v);
        req  = v.req;
        dst  = v.dst;
        done = v.done;
        @(posedge clk);
        #1;
        check_outs(tag, idx, v);
    endtask

    initial begin
        req  = '0;
        dst  = '0;
        done = '0;

        // unicast, no conflict
        tbl.push_back(mk(4'b0011, 16'h0084, 4'b0000, 4'b0011, 4'b0011, 4'b1100, 8'h40, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0000, 16'h0084, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 8'h40, 4'h0, 1'b0));
        // round-robin contention on O1
        tbl.push_back(mk(4'b0111, 16'h0222, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 8'h40, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0110, 16'h0222, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h40, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0110, 16'h0222, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 8'h44, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0100, 16'h0222, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h44, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0100, 16'h0222, 4'b0000, 4'b0100, 4'b0100, 4'b0010, 8'h48, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0000, 16'h0222, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'h48, 4'h0, 1'b0));
        tbl.push_back(mk(4'b1001, 16'h2002, 4'b0000, 4'b1000, 4'b1000, 4'b0010, 8'h4C, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0001, 16'h2002, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 8'h4C, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0001, 16'h2002, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 8'h40, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0000, 16'h2002, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h40, 4'h0, 1'b0));
        tbl.push_back(mk(4'b1000, 16'h2000, 4'b0000, 4'b1000, 4'b1000, 4'b0010, 8'h4C, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0000, 16'h2000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 8'h4C, 4'h0, 1'b0));
        // multicast all-or-nothing behind a locked O2
        tbl.push_back(mk(4'b1000, 16'h4000, 4'b0000, 4'b1000, 4'b1000, 4'b0100, 8'h7C, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0011, 16'h4026, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 8'h7C, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0011, 16'h4026, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 8'h7C, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0011, 16'h4026, 4'b0000, 4'b0001, 4'b0001, 4'b0110, 8'h40, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0010, 16'h4026, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h40, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0010, 16'h4026, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 8'h44, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0000, 16'h4026, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h44, 4'h0, 1'b0));
        // idle done, empty mask, done+req in the same cycle
        tbl.push_back(mk(4'b0000, 16'h0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'h44, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0100, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h44, 4'h0, 1'b1));
        tbl.push_back(mk(4'b0100, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h44, 4'h0, 1'b1));
        tbl.push_back(mk(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h44, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0100, 16'h0100, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 8'h46, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0100, 16'h0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'h46, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0100, 16'h0100, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 8'h46, 4'h0, 1'b0));
        tbl.push_back(mk(4'b0000, 16'h0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'h46, 4'h0, 1'b0));

        // Reset state, held asynchronously before any clock edge
        #2;
        check_outs("reset", 0, mk(4'h0, 16'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply("tbl", i, tbl[i]);
        end

        // Starvation: P1/P2 hold O1/O2 while P0 wants all four outputs
        apply("starve", 0, mk(4'b0110, 16'h0420, 4'b0000, 4'b0110, 4'b0110, 4'b0110, 8'h66, 4'h0, 1'b0));
        apply("starve", 1, mk(4'b0001, 16'h842F, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 8'h66, 4'h0, 1'b0));
        apply("starve", 2, mk(4'b1001, 16'h842F, 4'b0000, 4'b1000, 4'b1110, 4'b1110, 8'hE6, 4'h0, 1'b0));
        apply("starve", 3, mk(4'b0001, 16'h842F, 4'b1000, 4'b0000, 4'b0110, 4'b0110, 8'hE6, 4'h0, 1'b0));
        for (int w = 4; w <= 11; w++) begin
            apply("starve", w, mk(4'b0001, 16'h842F, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 8'hE6, 4'h0, 1'b0));
        end
        apply("starve", 12, mk(4'b0001, 16'h842F, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 8'hE6, 4'h1, 1'b0));
        // P3 would win O0 by round-robin, but O0 is reserved for urgent P0
        apply("urgent", 1, mk(4'b1001, 16'h142F, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 8'hE6, 4'h1, 1'b0));
        apply("urgent", 2, mk(4'b1001, 16'h142F, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 8'hE6, 4'h1, 1'b0));
        apply("urgent", 3, mk(4'b1001, 16'h142F, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 8'hE6, 4'h1, 1'b0));
        apply("urgent", 4, mk(4'b1001, 16'h142F, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'hE6, 4'h1, 1'b0));
        apply("urgent", 5, mk(4'b1001, 16'h142F, 4'b0000, 4'b0001, 4'b0001, 4'b1111, 8'h00, 4'h0, 1'b0));
        apply("urgent", 6, mk(4'b1000, 16'h142F, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'h0, 1'b0));
        apply("urgent", 7, mk(4'b1000, 16'h142F, 4'b0000, 4'b1000, 4'b1000, 4'b0001, 8'h03, 4'h0, 1'b0));
        apply("urgent", 8, mk(4'b0000, 16'h142F, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 8'h03, 4'h0, 1'b0));

        // Reset while P0 and P2 hold connections
        apply("rst", 0, mk(4'b0101, 16'h0401, 4'b0000, 4'b0101, 4'b0101, 4'b0101, 8'h20, 4'h0, 1'b0));
        req  = '0;
        dst  = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", 0, mk(4'h0, 16'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0));
        @(posedge clk);
        #1;
        check_outs("rst_hold", 0, mk(4'h0, 16'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        // Pointers restart at 0, so P0 beats P1 on O1
        apply("rst", 1, mk(4'b0011, 16'h0022, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 8'h00, 4'h0, 1'b0));
        apply("rst", 2, mk(4'b0010, 16'h0022, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'h0, 1'b0));
        apply("rst", 3, mk(4'b0010, 16'h0022, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 8'h04, 4'h0, 1'b0));
        apply("rst", 4, mk(4'b0000, 16'h0022, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h04, 4'h0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
